// File: rtl/tm_qm_assoc_rd_arb.sv
// Read-port arbiter for the queue association memory. Two first-level queue-manager
// clients (enq, deq) post single-cycle read requests. Requests are latched, granted
// round-robin and issued one at a time. Each memory ack/rdata goes back to the owning
// client. A watchdog completes the read with zero data if the memory never acks.

`ifndef FIRST_LVL_QUEUE_ID_NBITS
`define FIRST_LVL_QUEUE_ID_NBITS 8
`endif
`ifndef QUEUE_ASSOCIATION_NBITS
`define QUEUE_ASSOCIATION_NBITS 12
`endif

module tm_qm_assoc_rd_arb #(
   parameter int unsigned ID_NBITS = `FIRST_LVL_QUEUE_ID_NBITS,
   parameter int unsigned QA_NBITS = `QUEUE_ASSOCIATION_NBITS,
   parameter int unsigned TIMEOUT  = 63,
   parameter int unsigned TO_NBITS = 6
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                enq_qa_rd,
   input  logic [ID_NBITS-1:0] enq_qa_raddr,
   output logic                enq_qa_busy,
   output logic                enq_qa_ack,
   output logic [QA_NBITS-1:0] enq_qa_rdata,

   input  logic                deq_qa_rd,
   input  logic [ID_NBITS-1:0] deq_qa_raddr,
   output logic                deq_qa_busy,
   output logic                deq_qa_ack,
   output logic [QA_NBITS-1:0] deq_qa_rdata,

   output logic                queue_association_rd,
   output logic [ID_NBITS-1:0] queue_association_raddr,
   input  logic                queue_association_ack,
   input  logic [QA_NBITS-1:0] queue_association_rdata,

   output logic                req_drop_err,
   output logic                timeout_err,
   output logic                stray_ack_err
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e              state_q, state_d;
   // last_grant: 0 = enq, 1 = deq. It also names the owner of the read in flight.
   logic                last_grant_q, last_grant_d;
   logic                pend_enq_q, pend_enq_d;
   logic                pend_deq_q, pend_deq_d;
   logic [ID_NBITS-1:0] addr_enq_q, addr_enq_d;
   logic [ID_NBITS-1:0] addr_deq_q, addr_deq_d;
   logic [TO_NBITS-1:0] cnt_q, cnt_d;
   logic                qa_rd_q, qa_rd_d;
   logic [ID_NBITS-1:0] qa_raddr_q, qa_raddr_d;
   logic                enq_ack_q, enq_ack_d;
   logic                deq_ack_q, deq_ack_d;
   logic [QA_NBITS-1:0] enq_rdata_q, enq_rdata_d;
   logic [QA_NBITS-1:0] deq_rdata_q, deq_rdata_d;
   logic                drop_err_q, drop_err_d;
   logic                timeout_err_q, timeout_err_d;
   logic                stray_err_q, stray_err_d;

   logic                req_enq, req_deq, grant_deq;
   logic                done;
   logic [QA_NBITS-1:0] done_data;

   // Next-state: request latching, arbitration, issue, wait/watchdog and completion
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      pend_enq_d    = pend_enq_q;
      pend_deq_d    = pend_deq_q;
      addr_enq_d    = addr_enq_q;
      addr_deq_d    = addr_deq_q;
      cnt_d         = cnt_q;
      qa_rd_d       = 1'b0;
      qa_raddr_d    = qa_raddr_q;
      enq_ack_d     = 1'b0;
      deq_ack_d     = 1'b0;
      enq_rdata_d   = enq_rdata_q;
      deq_rdata_d   = deq_rdata_q;
      drop_err_d    = 1'b0;
      timeout_err_d = 1'b0;
      stray_err_d   = 1'b0;
      req_enq       = 1'b0;
      req_deq       = 1'b0;
      grant_deq     = 1'b0;
      done          = 1'b0;
      done_data     = '0;

      // A request from a client that already has one pending is dropped.
      if (enq_qa_rd) begin
         if (pend_enq_q) begin
            drop_err_d = 1'b1;
         end else begin
            pend_enq_d = 1'b1;
            addr_enq_d = enq_qa_raddr;
         end
      end
      if (deq_qa_rd) begin
         if (pend_deq_q) begin
            drop_err_d = 1'b1;
         end else begin
            pend_deq_d = 1'b1;
            addr_deq_d = deq_qa_raddr;
         end
      end

      unique case (state_q)
         StIdle: begin
            // Arriving requests bypass the latch so they can be granted this cycle.
            req_enq   = pend_enq_q | enq_qa_rd;
            req_deq   = pend_deq_q | deq_qa_rd;
            grant_deq = req_deq & (~req_enq | ~last_grant_q);
            if (req_enq || req_deq) begin
               last_grant_d = grant_deq;
               state_d      = StIssue;
               qa_rd_d      = 1'b1;
               if (grant_deq) begin
                  qa_raddr_d = pend_deq_q ? addr_deq_q : deq_qa_raddr;
               end else begin
                  qa_raddr_d = pend_enq_q ? addr_enq_q : enq_qa_raddr;
               end
            end
            if (queue_association_ack) begin
               stray_err_d = 1'b1;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
            if (queue_association_ack) begin
               stray_err_d = 1'b1;
            end
         end
         StWait: begin
            cnt_d = cnt_q + TO_NBITS'(1);
            // A real ack beats a watchdog expiry in the same cycle.
            if (queue_association_ack) begin
               done      = 1'b1;
               done_data = queue_association_rdata;
            end else if (cnt_q == TO_NBITS'(TIMEOUT - 1)) begin
               done          = 1'b1;
               timeout_err_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (done) begin
         state_d = StIdle;
         if (last_grant_q) begin
            deq_ack_d   = 1'b1;
            deq_rdata_d = done_data;
            pend_deq_d  = 1'b0;
         end else begin
            enq_ack_d   = 1'b1;
            enq_rdata_d = done_data;
            pend_enq_d  = 1'b0;
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         last_grant_q  <= 1'b1;
         pend_enq_q    <= 1'b0;
         pend_deq_q    <= 1'b0;
         addr_enq_q    <= '0;
         addr_deq_q    <= '0;
         cnt_q         <= '0;
         qa_rd_q       <= 1'b0;
         qa_raddr_q    <= '0;
         enq_ack_q     <= 1'b0;
         deq_ack_q     <= 1'b0;
         enq_rdata_q   <= '0;
         deq_rdata_q   <= '0;
         drop_err_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         stray_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         pend_enq_q    <= pend_enq_d;
         pend_deq_q    <= pend_deq_d;
         addr_enq_q    <= addr_enq_d;
         addr_deq_q    <= addr_deq_d;
         cnt_q         <= cnt_d;
         qa_rd_q       <= qa_rd_d;
         qa_raddr_q    <= qa_raddr_d;
         enq_ack_q     <= enq_ack_d;
         deq_ack_q     <= deq_ack_d;
         enq_rdata_q   <= enq_rdata_d;
         deq_rdata_q   <= deq_rdata_d;
         drop_err_q    <= drop_err_d;
         timeout_err_q <= timeout_err_d;
         stray_err_q   <= stray_err_d;
      end
   end

   assign enq_qa_busy             = pend_enq_q;
   assign enq_qa_ack              = enq_ack_q;
   assign enq_qa_rdata            = enq_rdata_q;
   assign deq_qa_busy             = pend_deq_q;
   assign deq_qa_ack              = deq_ack_q;
   assign deq_qa_rdata            = deq_rdata_q;
   assign queue_association_rd    = qa_rd_q;
   assign queue_association_raddr = qa_raddr_q;
   assign req_drop_err            = drop_err_q;
   assign timeout_err             = timeout_err_q;
   assign stray_ack_err           = stray_err_q;

endmodule

// File: tb/tb_tm_qm_assoc_rd_arb.sv
// Bench for tm_qm_assoc_rd_arb: transaction-level model with timestamps, directed
// scenarios with literal expectations, then a randomized soak.

module tb_tm_qm_assoc_rd_arb;

   localparam int unsigned ID_NBITS = 8;
   localparam int unsigned QA_NBITS = 12;
   localparam int unsigned TIMEOUT  = 63;
   localparam int unsigned TO_NBITS = 6;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                enq_qa_rd = 1'b0;
   logic [ID_NBITS-1:0] enq_qa_raddr = '0;
   logic                enq_qa_busy, enq_qa_ack;
   logic [QA_NBITS-1:0] enq_qa_rdata;
   logic                deq_qa_rd = 1'b0;
   logic [ID_NBITS-1:0] deq_qa_raddr = '0;
   logic                deq_qa_busy, deq_qa_ack;
   logic [QA_NBITS-1:0] deq_qa_rdata;
   logic                queue_association_rd;
   logic [ID_NBITS-1:0] queue_association_raddr;
   logic                queue_association_ack = 1'b0;
   logic [QA_NBITS-1:0] queue_association_rdata = '0;
   logic                req_drop_err, timeout_err, stray_ack_err;

   tm_qm_assoc_rd_arb #(
      .ID_NBITS (ID_NBITS),
      .QA_NBITS (QA_NBITS),
      .TIMEOUT  (TIMEOUT),
      .TO_NBITS (TO_NBITS)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .enq_qa_rd               (enq_qa_rd),
      .enq_qa_raddr            (enq_qa_raddr),
      .enq_qa_busy             (enq_qa_busy),
      .enq_qa_ack              (enq_qa_ack),
      .enq_qa_rdata            (enq_qa_rdata),
      .deq_qa_rd               (deq_qa_rd),
      .deq_qa_raddr            (deq_qa_raddr),
      .deq_qa_busy             (deq_qa_busy),
      .deq_qa_ack              (deq_qa_ack),
      .deq_qa_rdata            (deq_qa_rdata),
      .queue_association_rd    (queue_association_rd),
      .queue_association_raddr (queue_association_raddr),
      .queue_association_ack   (queue_association_ack),
      .queue_association_rdata (queue_association_rdata),
      .req_drop_err            (req_drop_err),
      .timeout_err             (timeout_err),
      .stray_ack_err           (stray_ack_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit m_valid = 1'b0;

   // Model: per-client pending flag and address, owner of the read in flight (-1 none)
   // and the cycle its strobe appears on the memory port.
   bit                  m_pend [2];
   logic [ID_NBITS-1:0] m_addr [2];
   int                  m_lastg = 1;
   int                  m_owner = -1;
   int                  m_t_issue = 0;

   // Expected outputs for the current cycle.
   bit                  e_busy [2];
   bit                  e_ack [2];
   logic [QA_NBITS-1:0] e_rdata [2];
   bit                  e_qrd, e_drop, e_to, e_stray;
   logic [ID_NBITS-1:0] e_qaddr;

   // Memory responder: 0 = ack after latency, 1 = never ack, 2 = ack at watchdog boundary.
   int                  resp_mode = 0;
   bit                  resp_rand = 1'b0;
   int                  resp_lat  = 1;
   logic [QA_NBITS-1:0] resp_data = '0;
   int                  ack_at    = -1;
   logic [QA_NBITS-1:0] ack_data  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic schedule_ack();
      int lat;
      lat      = resp_rand ? int'($urandom_range(1, 6)) : resp_lat;
      ack_data = resp_rand ? QA_NBITS'($urandom) : resp_data;
      if (resp_mode == 1 || (resp_rand && $urandom_range(0, 19) == 0)) ack_at = -1;
      else if (resp_mode == 2) ack_at = m_t_issue + int'(TIMEOUT);
      else ack_at = m_t_issue + lat;
   endtask

   task automatic finish_read(input logic [QA_NBITS-1:0] d, inout bit np [2]);
      e_ack[m_owner]   = 1'b1;
      e_rdata[m_owner] = d;
      np[m_owner]      = 1'b0;
      m_owner          = -1;
   endtask

   // Advance the model by the cycle whose inputs were just sampled.
   task automatic model_step();
      bit                  rd [2];
      logic [ID_NBITS-1:0] ra [2];
      bit                  np [2];
      bit                  r0, r1;
      int                  g;
      e_qrd = 1'b0; e_drop = 1'b0; e_to = 1'b0; e_stray = 1'b0;
      e_ack[0] = 1'b0; e_ack[1] = 1'b0;
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            m_pend[c] = 1'b0; m_addr[c] = '0; e_busy[c] = 1'b0; e_rdata[c] = '0;
         end
         e_qaddr = '0; m_lastg = 1; m_owner = -1; ack_at = -1;
         return;
      end
      rd[0] = enq_qa_rd; ra[0] = enq_qa_raddr;
      rd[1] = deq_qa_rd; ra[1] = deq_qa_raddr;
      np[0] = m_pend[0]; np[1] = m_pend[1];
      if (queue_association_ack && (m_owner < 0 || cyc == m_t_issue)) e_stray = 1'b1;
      if (m_owner < 0) begin
         r0 = m_pend[0] | rd[0];
         r1 = m_pend[1] | rd[1];
         if (r0 || r1) begin
            if (r0 && r1) g = (m_lastg == 0) ? 1 : 0;
            else g = r1 ? 1 : 0;
            e_qaddr   = m_pend[g] ? m_addr[g] : ra[g];
            e_qrd     = 1'b1;
            m_lastg   = g;
            m_owner   = g;
            m_t_issue = cyc + 1;
            schedule_ack();
         end
      end else if (cyc > m_t_issue) begin
         if (queue_association_ack) begin
            finish_read(queue_association_rdata, np);
         end else if (cyc - m_t_issue == int'(TIMEOUT)) begin
            e_to = 1'b1;
            finish_read('0, np);
         end
      end
      for (int c = 0; c < 2; c++) begin
         if (rd[c]) begin
            if (m_pend[c]) e_drop = 1'b1;
            else begin
               np[c]     = 1'b1;
               m_addr[c] = ra[c];
            end
         end
         // A read completing this cycle owns the pend flag; the rd above was a drop.
         m_pend[c] = np[c];
         e_busy[c] = np[c];
      end
   endtask

   task automatic compare_all();
      if (!m_valid) return;
      chk("enq_busy", 32'(enq_qa_busy), 32'(e_busy[0]));
      chk("enq_ack", 32'(enq_qa_ack), 32'(e_ack[0]));
      chk("enq_rdata", 32'(enq_qa_rdata), 32'(e_rdata[0]));
      chk("deq_busy", 32'(deq_qa_busy), 32'(e_busy[1]));
      chk("deq_ack", 32'(deq_qa_ack), 32'(e_ack[1]));
      chk("deq_rdata", 32'(deq_qa_rdata), 32'(e_rdata[1]));
      chk("qa_rd", 32'(queue_association_rd), 32'(e_qrd));
      chk("qa_raddr", 32'(queue_association_raddr), 32'(e_qaddr));
      chk("drop_err", 32'(req_drop_err), 32'(e_drop));
      chk("timeout_err", 32'(timeout_err), 32'(e_to));
      chk("stray_err", 32'(stray_ack_err), 32'(e_stray));
   endtask

   // One clock: model consumes this cycle's inputs, then outputs of the next cycle are
   // checked and default inputs are applied; the caller may override them afterwards.
   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      m_valid = 1'b1;
      @(negedge clk);
      compare_all();
      enq_qa_rd = 1'b0;
      deq_qa_rd = 1'b0;
      if (cyc == ack_at) begin
         queue_association_ack   = 1'b1;
         queue_association_rdata = ack_data;
      end else begin
         queue_association_ack   = 1'b0;
         queue_association_rdata = QA_NBITS'($urandom);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int n_iss, n_rd, n_ack;
      @(negedge clk);
      do_reset();
      chk("reset_busy", 32'(enq_qa_busy | deq_qa_busy), 32'h0);
      chk("reset_qa_rd", 32'(queue_association_rd), 32'h0);

      // Single read, memory acks 3 cycles after the strobe.
      resp_mode = 0; resp_rand = 1'b0; resp_lat = 3; resp_data = 12'h1A2;
      enq_qa_rd = 1'b1; enq_qa_raddr = 8'h05;
      tick();
      chk("sr_rd", 32'(queue_association_rd), 32'h1);
      chk("sr_addr", 32'(queue_association_raddr), 32'h05);
      repeat (3) tick();
      chk("sr_no_early_ack", 32'(enq_qa_ack), 32'h0);
      tick();
      chk("sr_ack", 32'(enq_qa_ack), 32'h1);
      chk("sr_rdata", 32'(enq_qa_rdata), 32'h1A2);
      chk("sr_busy", 32'(enq_qa_busy), 32'h0);
      repeat (4) tick();

      // Tie after reset, then continuous alternation.
      do_reset();
      resp_lat = 1; resp_data = 12'h0C3;
      enq_qa_rd = 1'b1; enq_qa_raddr = 8'h03;
      deq_qa_rd = 1'b1; deq_qa_raddr = 8'h07;
      tick();
      chk("tie_first", 32'(queue_association_raddr), 32'h03);
      repeat (3) tick();
      chk("tie_second_rd", 32'(queue_association_rd), 32'h1);
      chk("tie_second", 32'(queue_association_raddr), 32'h07);
      n_iss = 2;
      for (int i = 0; i < 200 && n_iss < 8; i++) begin
         enq_qa_rd = !e_busy[0]; enq_qa_raddr = 8'h03;
         deq_qa_rd = !e_busy[1]; deq_qa_raddr = 8'h07;
         tick();
         if (queue_association_rd) begin
            chk("alt_order", 32'(queue_association_raddr), (n_iss % 2 == 0) ? 32'h03 : 32'h07);
            n_iss++;
         end
      end
      chk("alt_count", n_iss, 8);
      repeat (8) tick();

      // Drop while busy.
      resp_lat = 4; resp_data = 12'h2B4;
      deq_qa_rd = 1'b1; deq_qa_raddr = 8'h10;
      n_rd = 0; n_ack = 0;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (queue_association_rd) begin
            n_rd++;
            chk("drop_addr", 32'(queue_association_raddr), 32'h10);
         end
         if (deq_qa_ack) n_ack++;
         if (i == 2) begin
            deq_qa_rd = 1'b1; deq_qa_raddr = 8'h11;
         end
         if (i == 3) chk("drop_pulse", 32'(req_drop_err), 32'h1);
      end
      chk("drop_n_rd", n_rd, 1);
      chk("drop_n_ack", n_ack, 1);

      // Watchdog expiry, then a late ack.
      resp_mode = 1;
      enq_qa_rd = 1'b1; enq_qa_raddr = 8'h21;
      for (int i = 1; i <= 70; i++) begin
         tick();
         if (i == 64) chk("to_not_yet", 32'(timeout_err | enq_qa_ack), 32'h0);
         if (i == 65) begin
            chk("to_ack", 32'(enq_qa_ack), 32'h1);
            chk("to_err", 32'(timeout_err), 32'h1);
            chk("to_rdata", 32'(enq_qa_rdata), 32'h0);
         end
         if (i == 67) queue_association_ack = 1'b1;
         if (i == 68) begin
            chk("late_stray", 32'(stray_ack_err), 32'h1);
            chk("late_no_ack", 32'(enq_qa_ack | deq_qa_ack), 32'h0);
         end
      end

      // Ack on the last watchdog cycle wins.
      resp_mode = 2; resp_data = 12'h155;
      deq_qa_rd = 1'b1; deq_qa_raddr = 8'h02;
      for (int i = 1; i <= 68; i++) begin
         tick();
         if (i == 65) begin
            chk("bnd_ack", 32'(deq_qa_ack), 32'h1);
            chk("bnd_rdata", 32'(deq_qa_rdata), 32'h155);
            chk("bnd_no_to", 32'(timeout_err), 32'h0);
         end
      end

      // Reset while waiting with both clients pending.
      resp_mode = 1;
      enq_qa_rd = 1'b1; enq_qa_raddr = 8'h31;
      deq_qa_rd = 1'b1; deq_qa_raddr = 8'h32;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rw_busy", 32'({enq_qa_busy, deq_qa_busy}), 32'h0);
      chk("rw_qa", 32'({queue_association_rd, queue_association_raddr}), 32'h0);
      chk("rw_rdata", 32'({enq_qa_rdata, deq_qa_rdata}), 32'h0);
      n_ack = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (enq_qa_ack || deq_qa_ack) n_ack++;
      end
      chk("rw_no_acks", n_ack, 0);
      resp_mode = 0; resp_lat = 2; resp_data = 12'h0AB;
      deq_qa_rd = 1'b1; deq_qa_raddr = 8'h09;
      repeat (4) tick();
      chk("rw_after_ack", 32'(deq_qa_ack), 32'h1);
      chk("rw_after_rdata", 32'(deq_qa_rdata), 32'h0AB);
      repeat (4) tick();

      // Randomized soak: random requests, latencies, stray acks and occasional reset.
      resp_mode = 0; resp_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 499) == 0);
         enq_qa_rd    = ($urandom_range(0, 3) == 0);
         enq_qa_raddr = ID_NBITS'($urandom);
         deq_qa_rd    = ($urandom_range(0, 3) == 0);
         deq_qa_raddr = ID_NBITS'($urandom);
         if ($urandom_range(0, 39) == 0) queue_association_ack = 1'b1;
         tick();
      end
      rst = 1'b0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
